// File: rtl/cache_miss_handler.sv
// Miss/refill engine behind a fully-associative data cache.
// On a lookup miss it writes back a dirty victim to memory and reads the missing word
// (loads only). It then installs the line through a one-cycle fill strobe.
// The requester is stalled for the whole sequence.
module cache_miss_handler #(
  parameter int DATAW = 32,
  parameter int TAGW  = 6,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic             req_write,
  input  logic [TAGW-1:0]  req_tag,
  input  logic [DATAW-1:0] req_data,
  input  logic             lk_hit,
  input  logic             lk_dirty,
  input  logic [TAGW-1:0]  victim_tag,
  input  logic [DATAW-1:0] victim_data,
  output logic             stall,
  output logic             fill_en,
  output logic [TAGW-1:0]  fill_tag,
  output logic [DATAW-1:0] fill_data,
  output logic             fill_dirty,
  output logic             mem_req_valid,
  output logic             mem_req_write,
  output logic [TAGW-1:0]  mem_req_addr,
  output logic [DATAW-1:0] mem_req_data,
  input  logic             mem_req_ready,
  input  logic             mem_rsp_valid,
  input  logic [DATAW-1:0] mem_rsp_data,
  output logic [CNTW-1:0]  miss_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB,
    S_RD,
    S_WAIT,
    S_FILL
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_miss;
  logic             r_write;
  logic [TAGW-1:0]  r_tag;
  logic [DATAW-1:0] r_data;
  logic [TAGW-1:0]  r_vtag;
  logic [DATAW-1:0] r_vdata;
  logic [DATAW-1:0] r_rsp;
  logic [CNTW-1:0]  r_miss_cnt;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    if (&v) return v;
    return v + 1'b1;
  endfunction

  // A new miss is only accepted while idle; FILL always returns to IDLE first.
  assign w_miss     = (r_state == S_IDLE) & req_valid & ~lk_hit;
  assign miss_count = r_miss_cnt;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Capture the missing request and its victim in the detect cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
      r_vtag  <= '0;
      r_vdata <= '0;
    end else if (w_miss) begin
      r_write <= req_write;
      r_tag   <= req_tag;
      r_data  <= req_data;
      r_vtag  <= victim_tag;
      r_vdata <= victim_data;
    end
  end

  // Read data is only taken while waiting for it; strays elsewhere are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   r_rsp <= '0;
    else if (r_state == S_WAIT && mem_rsp_valid) r_rsp <= mem_rsp_data;
  end

  // Saturating count of accepted misses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_miss_cnt <= '0;
    else if (w_miss) r_miss_cnt <= sat_inc(r_miss_cnt);
  end

  // Next state and outputs; memory request fields come only from registers,
  // so they stay constant while a request waits for ready.
  always_comb begin
    w_next        = r_state;
    fill_en       = 1'b0;
    fill_tag      = '0;
    fill_data     = '0;
    fill_dirty    = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_write = 1'b0;
    mem_req_addr  = '0;
    mem_req_data  = '0;
    case (r_state)
      S_IDLE: begin
        if (req_valid && !lk_hit) begin
          if (lk_dirty)       w_next = S_WB;
          else if (!req_write) w_next = S_RD;
          else                 w_next = S_FILL;
        end
      end
      S_WB: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = r_vtag;
        mem_req_data  = r_vdata;
        if (mem_req_ready) w_next = r_write ? S_FILL : S_RD;
      end
      S_RD: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = r_tag;
        if (mem_req_ready) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rsp_valid) w_next = S_FILL;
      end
      S_FILL: begin
        fill_en    = 1'b1;
        fill_tag   = r_tag;
        fill_data  = r_write ? r_data : r_rsp;
        fill_dirty = r_write;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Mealy stall: a miss holds the requester in its detect cycle. Held low during
  // reset so every output reads zero while rst_n is asserted.
  assign stall = rst_n & ((r_state != S_IDLE) | (req_valid & ~lk_hit));

endmodule
